// File: rtl/spi_router_pkg.sv
// spi_router_pkg: shared defaults, port ID type and destination-field helper for the SPI packet router.
package spi_router_pkg;
    localparam int default_nbits = 32;
    localparam int default_num_ports = 4;
    localparam int default_order_depth = 4;
    localparam int default_addr_bits = $clog2(default_num_ports);
    typedef logic [default_addr_bits-1:0] port_id_t;
    function automatic port_id_t get_dest(input logic [default_nbits-1:0] msg);
        return msg[default_nbits-1 -: default_addr_bits];
    endfunction
endpackage

// File: rtl/spi_router_order_fifo.sv
// spi_router_order_fifo: in-order queue of destination IDs for outstanding requests.
module spi_router_order_fifo #(
    parameter int depth = 4,
    parameter int width = 2,
    localparam int ptr_bits = $clog2(depth),
    localparam int cnt_bits = ptr_bits + 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                push_i,
    input  logic                pop_i,
    input  logic [width-1:0]    din_i,
    output logic [width-1:0]    dout_o,
    output logic                full_o,
    output logic                empty_o,
    output logic [cnt_bits-1:0] count_o
);
    logic [width-1:0]    mem_q [depth];
    logic [ptr_bits-1:0] wr_q, rd_q;
    logic [cnt_bits-1:0] count_q, count_d;
    logic                full_q, do_push, do_pop;

    // push is refused while full even if a pop happens this cycle, so full never depends on pop
    always_comb begin
        do_push = push_i & ~full_q;
        do_pop  = pop_i & (count_q != '0);
        count_d = count_q + cnt_bits'(do_push) - cnt_bits'(do_pop);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop) rd_q <= rd_q + 1'b1;
            count_q <= count_d;
            full_q  <= (count_d == cnt_bits'(depth));
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din_i;
    end

    assign dout_o  = mem_q[rd_q];
    assign full_o  = full_q;
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
endmodule

// File: rtl/spi_packet_router.sv
// spi_packet_router: routes SPI request packets to endpoints by destination field and
// returns endpoint responses in request order, tagged with the source port.
module spi_packet_router
    import spi_router_pkg::*;
#(
    parameter int nbits = default_nbits,
    parameter int num_ports = default_num_ports,
    parameter int order_depth = default_order_depth,
    localparam int addr_bits = $clog2(num_ports),
    localparam int cnt_bits = $clog2(order_depth) + 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       recv_val,
    input  logic [nbits-1:0]           recv_msg,
    output logic                       recv_rdy,
    output logic                       send_val,
    output logic [nbits-1:0]           send_msg,
    input  logic                       send_rdy,
    output logic [num_ports-1:0]       port_req_val,
    output logic [nbits-1:0]           port_req_msg,
    input  logic [num_ports-1:0]       port_req_rdy,
    input  logic [num_ports-1:0]       port_resp_val,
    input  logic [num_ports*nbits-1:0] port_resp_msg,
    output logic [num_ports-1:0]       port_resp_rdy,
    output logic [cnt_bits-1:0]        outstanding
);
    logic [addr_bits-1:0] dest, head;
    logic                 full, empty, push, pop;
    logic [nbits-1:0]     resp_arr [num_ports];

    for (genvar g = 0; g < num_ports; g++) begin : g_resp
        assign resp_arr[g] = port_resp_msg[g*nbits +: nbits];
    end

    // request-side handshakes are gated by reset so nothing is offered while it is held
    always_comb begin
        dest         = recv_msg[nbits-1 -: addr_bits];
        recv_rdy     = reset & ~full & port_req_rdy[dest];
        port_req_msg = recv_msg;
        send_val     = ~empty & port_resp_val[head];
        send_msg     = resp_arr[head];
        send_msg[nbits-1 -: addr_bits] = head;
        for (int i = 0; i < num_ports; i++) begin
            port_req_val[i]  = reset & recv_val & ~full & (dest == addr_bits'(i));
            port_resp_rdy[i] = ~empty & (head == addr_bits'(i)) & send_rdy;
        end
        push = recv_val & recv_rdy;
        pop  = send_val & send_rdy;
    end

    spi_router_order_fifo #(
        .depth(order_depth),
        .width(addr_bits)
    ) u_order (
        .clk(clk),
        .reset(reset),
        .push_i(push),
        .pop_i(pop),
        .din_i(dest),
        .dout_o(head),
        .full_o(full),
        .empty_o(empty),
        .count_o(outstanding)
    );
endmodule

// File: tb/tb_spi_packet_router.sv
// tb_spi_packet_router: vector table plus scoreboarded sequences for the SPI packet router.
module tb_spi_packet_router;
    logic         clk = 1'b0, reset = 1'b0;
    logic         recv_val, recv_rdy, send_val, send_rdy;
    logic [31:0]  recv_msg, send_msg, port_req_msg;
    logic [3:0]   port_req_val, port_req_rdy, port_resp_val, port_resp_rdy;
    logic [127:0] port_resp_msg;
    logic [2:0]   outstanding;
    logic [31:0]  rd [4];
    logic [31:0]  pd [4];
    logic [31:0]  sb [$];
    logic [1:0]   id;
    logic [31:0]  d;
    int           stall;
    int           n_checks = 0, n_pass = 0;

    typedef struct {
        logic        val;
        logic [31:0] msg;
        logic [3:0]  req_rdy;
        logic [3:0]  exp_req_val;
        logic        exp_rdy;
    } vec_t;
    vec_t vecs [6];

    always #5 clk = ~clk;
    assign port_resp_msg = {rd[3], rd[2], rd[1], rd[0]};

    spi_packet_router dut (
        .clk(clk), .reset(reset),
        .recv_val(recv_val), .recv_msg(recv_msg), .recv_rdy(recv_rdy),
        .send_val(send_val), .send_msg(send_msg), .send_rdy(send_rdy),
        .port_req_val(port_req_val), .port_req_msg(port_req_msg), .port_req_rdy(port_req_rdy),
        .port_resp_val(port_resp_val), .port_resp_msg(port_resp_msg), .port_resp_rdy(port_resp_rdy),
        .outstanding(outstanding)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_resp(input string name);
        check({name, "_val"}, 32'(send_val), 32'd1);
        if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL %s: got %h expected nothing queued", name, send_msg);
        end else check(name, send_msg, sb.pop_front());
    endtask

    function automatic logic [31:0] tag(input logic [1:0] src, input logic [31:0] data);
        return {src, data[29:0]};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b1, 32'h8000_0012, 4'b0100, 4'b0100, 1'b1};
        vecs[1] = '{1'b1, 32'hC000_0001, 4'b0111, 4'b1000, 1'b0};
        vecs[2] = '{1'b0, 32'h4000_0000, 4'b1111, 4'b0000, 1'b1};
        vecs[3] = '{1'b1, 32'h0000_00FF, 4'b1110, 4'b0001, 1'b0};
        vecs[4] = '{1'b1, 32'h7FFF_FFFF, 4'b0010, 4'b0010, 1'b1};
        vecs[5] = '{1'b1, 32'hFFFF_FFFF, 4'b1111, 4'b1000, 1'b1};
        pd[0] = 32'hF000_0000;
        pd[1] = 32'h2111_1111;
        pd[2] = 32'h0000_ABCD;
        pd[3] = 32'h0333_3333;
        for (int i = 0; i < 4; i++) rd[i] = 32'h0;

        recv_val = 1'b1;
        recv_msg = 32'h8000_0012;
        port_req_rdy = 4'hF;
        port_resp_val = 4'hF;
        send_rdy = 1'b1;
        repeat (2) tick();
        check("rst_recv_rdy", 32'(recv_rdy), 32'd0);
        check("rst_req_val", 32'(port_req_val), 32'd0);
        check("rst_send_val", 32'(send_val), 32'd0);
        check("rst_resp_rdy", 32'(port_resp_rdy), 32'd0);
        check("rst_outstanding", 32'(outstanding), 32'd0);
        recv_val = 1'b0;
        port_resp_val = 4'h0;
        send_rdy = 1'b0;
        reset = 1'b1;
        tick();

        foreach (vecs[i]) begin
            recv_val = vecs[i].val;
            recv_msg = vecs[i].msg;
            port_req_rdy = vecs[i].req_rdy;
            port_resp_val = 4'hF;
            send_rdy = 1'b1;
            #1;
            check($sformatf("vec%0d_req_val", i), 32'(port_req_val), 32'(vecs[i].exp_req_val));
            check($sformatf("vec%0d_recv_rdy", i), 32'(recv_rdy), 32'(vecs[i].exp_rdy));
            check($sformatf("vec%0d_req_msg", i), port_req_msg, vecs[i].msg);
            check($sformatf("vec%0d_empty_send_val", i), 32'(send_val), 32'd0);
            check($sformatf("vec%0d_empty_resp_rdy", i), 32'(port_resp_rdy), 32'd0);
            recv_val = 1'b0;
            tick();
        end
        port_resp_val = 4'h0;
        check("vec_outstanding", 32'(outstanding), 32'd0);

        recv_val = 1'b1;
        recv_msg = 32'h8000_0012;
        port_req_rdy = 4'b0100;
        send_rdy = 1'b1;
        #1;
        check("rt_req_val", 32'(port_req_val), 32'h4);
        check("rt_recv_rdy", 32'(recv_rdy), 32'd1);
        sb.push_back(tag(2'd2, pd[2]));
        tick();
        recv_val = 1'b0;
        check("rt_out1", 32'(outstanding), 32'd1);
        rd[2] = pd[2];
        port_resp_val = 4'b0100;
        #1;
        check("rt_resp_rdy", 32'(port_resp_rdy), 32'h4);
        expect_resp("rt_msg");
        tick();
        port_resp_val = 4'h0;
        check("rt_out0", 32'(outstanding), 32'd0);

        port_req_rdy = 4'hF;
        for (int i = 0; i < 3; i++) begin
            id = (i == 0) ? 2'd3 : (i == 1) ? 2'd1 : 2'd0;
            recv_val = 1'b1;
            recv_msg = {id, 30'(i)};
            rd[id] = pd[id];
            sb.push_back(tag(id, pd[id]));
            tick();
        end
        recv_val = 1'b0;
        check("ord_out", 32'(outstanding), 32'd3);
        port_resp_val = 4'b0001;
        #1;
        check("ord_hold_val0", 32'(send_val), 32'd0);
        check("ord_hold_rdy0", 32'(port_resp_rdy), 32'h8);
        tick();
        port_resp_val = 4'b0011;
        #1;
        check("ord_hold_val1", 32'(send_val), 32'd0);
        check("ord_hold_rdy1", 32'(port_resp_rdy), 32'h8);
        tick();
        port_resp_val = 4'b1011;
        #1;
        expect_resp("ord_p3");
        check("ord_p0_held", 32'(port_resp_rdy[0]), 32'd0);
        tick();
        port_resp_val = 4'b0011;
        #1;
        check("ord_p1_rdy", 32'(port_resp_rdy), 32'h2);
        expect_resp("ord_p1");
        tick();
        port_resp_val = 4'b0001;
        #1;
        check("ord_p0_rdy", 32'(port_resp_rdy), 32'h1);
        expect_resp("ord_p0");
        tick();
        port_resp_val = 4'h0;
        check("ord_out0", 32'(outstanding), 32'd0);

        send_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            recv_val = 1'b1;
            recv_msg = {2'(i), 30'h1000};
            rd[i] = pd[i];
            sb.push_back(tag(2'(i), pd[i]));
            tick();
        end
        recv_msg = 32'h8000_0055;
        #1;
        check("full_out", 32'(outstanding), 32'd4);
        check("full_recv_rdy", 32'(recv_rdy), 32'd0);
        check("full_req_val", 32'(port_req_val), 32'd0);
        port_resp_val = 4'hF;
        send_rdy = 1'b1;
        #1;
        check("full_pop_recv_rdy", 32'(recv_rdy), 32'd0);
        expect_resp("full_pop");
        tick();
        send_rdy = 1'b0;
        #1;
        check("full_out3", 32'(outstanding), 32'd3);
        check("full_next_recv_rdy", 32'(recv_rdy), 32'd1);
        sb.push_back(tag(2'd2, pd[2]));
        tick();
        recv_val = 1'b0;
        check("full_out_refill", 32'(outstanding), 32'd4);
        send_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            expect_resp($sformatf("full_drain%0d", i));
            tick();
        end
        port_resp_val = 4'h0;
        check("full_out0", 32'(outstanding), 32'd0);

        recv_val = 1'b1;
        recv_msg = 32'h4000_00AA;
        port_req_rdy = 4'b1101;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("bp_recv_rdy%0d", i), 32'(recv_rdy), 32'd0);
            check($sformatf("bp_req_val%0d", i), 32'(port_req_val), 32'h2);
            check($sformatf("bp_out%0d", i), 32'(outstanding), 32'd0);
            tick();
        end
        port_req_rdy = 4'hF;
        #1;
        check("bp_recv_rdy_go", 32'(recv_rdy), 32'd1);
        sb.push_back(tag(2'd1, pd[1]));
        tick();
        recv_val = 1'b0;
        check("bp_out1", 32'(outstanding), 32'd1);
        rd[1] = pd[1];
        port_resp_val = 4'b0010;
        #1;
        expect_resp("bp_resp");
        tick();
        port_resp_val = 4'h0;

        for (int k = 0; k < 10; k++) begin
            id = 2'($urandom_range(0, 3));
            recv_val = 1'b1;
            recv_msg = {id, 30'(k * 7)};
            send_rdy = 1'b0;
            #1;
            check($sformatf("wrap%0d_recv_rdy", k), 32'(recv_rdy), 32'd1);
            tick();
            recv_val = 1'b0;
            d = $urandom;
            rd[id] = d;
            sb.push_back(tag(id, d));
            port_resp_val = 4'(1) << id;
            stall = $urandom_range(0, 2);
            repeat (stall) begin
                #1;
                check($sformatf("wrap%0d_stall_out", k), 32'(outstanding), 32'd1);
                tick();
            end
            send_rdy = 1'b1;
            #1;
            expect_resp($sformatf("wrap%0d_resp", k));
            tick();
            port_resp_val = 4'h0;
        end
        send_rdy = 1'b0;
        check("wrap_out0", 32'(outstanding), 32'd0);

        for (int i = 0; i < 3; i++) begin
            recv_val = 1'b1;
            recv_msg = {2'(i), 30'h5};
            tick();
        end
        recv_msg = 32'h0;
        port_resp_val = 4'hF;
        send_rdy = 1'b1;
        #1;
        check("ar_out3", 32'(outstanding), 32'd3);
        check("ar_send_val_pre", 32'(send_val), 32'd1);
        #1;
        reset = 1'b0;
        #1;
        check("ar_out", 32'(outstanding), 32'd0);
        check("ar_send_val", 32'(send_val), 32'd0);
        check("ar_recv_rdy", 32'(recv_rdy), 32'd0);
        check("ar_resp_rdy", 32'(port_resp_rdy), 32'd0);
        check("ar_req_val", 32'(port_req_val), 32'd0);
        sb.delete();
        recv_val = 1'b0;
        port_resp_val = 4'h0;
        send_rdy = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        check("ar_out_after", 32'(outstanding), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
